ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; legal values are 16, 32 and 64.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 startE  in  1  execute-stage M-extension instruction valid.
REQ-005 opE  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 fwdAE, fwdBE  in  2 each  forwarding select: 00 register, 01 resultM, 10 resultW, 11 register.
REQ-007 rs1valE, rs2valE, resultM, resultW  in  XLEN each  register operands and forwarding lines.
REQ-008 rdE  in  5  destination register tag.
REQ-009 flushE  in  1  abort the operation in flight.
REQ-010 busy  out  1  stall request to the hazard unit.
REQ-011 done  out  1  one-cycle result-valid pulse.
REQ-012 md_out  out  XLEN  result.
REQ-013 rd_out  out  5  tag of the completed result.

Function
REQ-014 Operand A/B SHALL be selected by fwdAE/fwdBE in the same cycle as startE and latched at the edge ending that cycle (cycle T).
REQ-015 FSM states: IDLE, MUL, DIV, DONE.
REQ-016 IDLE with startE=1 SHALL go to MUL (op[2]=0) or DIV (op[2]=1), load iteration counter = XLEN, and latch opE and rdE.
REQ-017 busy SHALL equal (startE & IDLE) | MUL | DIV, combinationally; busy SHALL be 0 in DONE.
REQ-018 startE SHALL be ignored while the FSM is not in IDLE.
REQ-019 MUL/DIV SHALL perform one radix-2 iteration per cycle on operand magnitudes (shift-add multiply, restoring divide), then go to DONE when the counter reaches 0.
REQ-020 Normal latency: done=1 in cycle T+XLEN+1, then IDLE.
REQ-021 Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU signed A, unsigned B; MULHU/DIVU/REMU unsigned.
REQ-022 Sign correction SHALL be applied on entry to DONE: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-023 Product SHALL be 2*XLEN bits; MUL returns bits [XLEN-1:0]; MULH* return bits [2*XLEN-1:XLEN].
REQ-024 Divide by zero SHALL go directly to DONE (done at T+2): quotient all ones, remainder = dividend.
REQ-025 Signed overflow (-2^(XLEN-1) / -1) SHALL go directly to DONE (done at T+2): quotient = dividend, remainder 0.
REQ-026 md_out and rd_out SHALL update on entry to DONE and hold until the next DONE.
REQ-027 flushE=1 in any state SHALL force IDLE at the next edge; no done pulse; md_out holds its previous value; flush has priority over startE.
REQ-028 done SHALL be registered, asserted only in DONE.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, busy=0, done=0, md_out=0, rd_out=0, and counter=0, including in the middle of an operation.
REQ-030 The first startE after rst deasserts SHALL be accepted normally.

Configuration
REQ-031 Macro MULDIV_EARLY_OUT_EN. When defined, a multiply with either selected operand equal to zero SHALL skip to DONE with result 0 (done at T+2). When undefined, such multiplies take the full T+XLEN+1 latency. Divide-by-zero and overflow shortcuts apply in both builds.

Verification (XLEN=32)
REQ-032 MUL with fwdAE=01, resultM=7, rs2valE=0xFFFFFFFD -> md_out=0xFFFFFFEB, done at T+33, busy high T..T+32.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIV 5/0 -> 0xFFFFFFFF at T+2; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+2.
REQ-036 flushE at T+10 -> no done pulse, busy=0 at T+11; startE at T+12 accepted; also a startE asserted at T+5 during the op is ignored.
REQ-037 rst pulsed mid-op at T+15 -> outputs zero immediately, no done; with MULDIV_EARLY_OUT_EN defined, MUL 0 x 9 -> 0 at T+2.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage multiply/divide unit port bundle.
// The pipeline drives the master side and the unit drives the slave side.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            startE;
  logic [2:0]      opE;
  logic [1:0]      fwdAE;
  logic [1:0]      fwdBE;
  logic [XLEN-1:0] rs1valE;
  logic [XLEN-1:0] rs2valE;
  logic [XLEN-1:0] resultM;
  logic [XLEN-1:0] resultW;
  logic [4:0]      rdE;
  logic            flushE;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] md_out;
  logic [4:0]      rd_out;

  modport master (
    output startE, opE, fwdAE, fwdBE, rs1valE, rs2valE, resultM, resultW, rdE, flushE,
    input  busy, done, md_out, rd_out
  );

  modport slave (
    input  startE, opE, fwdAE, fwdBE, rs1valE, rs2valE, resultM, resultW, rdE, flushE,
    output busy, done, md_out, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle on operand magnitudes (shift-add multiply,
// restoring divide), with the sign fix-up applied when the result is written.
// Divide-by-zero and signed-overflow divides take a two-cycle shortcut.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies by zero also take the
// two-cycle shortcut and return 0.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  ex_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL1    = {XLEN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] m, input logic [XLEN-1:0] w);
    case (sel)
      2'b01:   return m;
      2'b10:   return w;
      default: return rf;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] md_q, md_d;
  logic [4:0]      rdo_q, rdo_d;
  logic            done_q, done_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // product low half / quotient, or shortcut result
  logic [XLEN-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
  logic            neg_q, neg_d;   // negate product or quotient
  logic            negr_q, negr_d; // negate remainder (dividend was negative)
  logic            short_q, short_d;

  // Operand selection and sign analysis for the instruction in execute
  logic [XLEN-1:0] opa, opb, a_mag, b_mag, special_res;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, early, special;

  assign opa      = fwd_sel(bus.fwdAE, bus.rs1valE, bus.resultM, bus.resultW);
  assign opb      = fwd_sel(bus.fwdBE, bus.rs2valE, bus.resultM, bus.resultW);
  assign a_signed = bus.opE[2] ? ~bus.opE[0] : (bus.opE[1:0] != 2'b11);
  assign b_signed = bus.opE[2] ? ~bus.opE[0] : ~bus.opE[1];
  assign a_neg    = a_signed & opa[XLEN-1];
  assign b_neg    = b_signed & opb[XLEN-1];
  assign a_mag    = cneg(a_neg, opa);
  assign b_mag    = cneg(b_neg, opb);
  assign div_zero = bus.opE[2] & (opb == '0);
  assign div_ovf  = bus.opE[2] & ~bus.opE[0] & (opa == MIN_NEG) & (opb == ALL1);
`ifdef MULDIV_EARLY_OUT_EN
  assign early    = ~bus.opE[2] & ((opa == '0) | (opb == '0));
`else
  assign early    = 1'b0;
`endif
  assign special  = div_zero | div_ovf | early;
  // REM/REMU have opE[1] set; remainder of x/0 is x, remainder of overflow is 0
  assign special_res = div_zero ? (bus.opE[1] ? opa : ALL1) :
                       div_ovf  ? (bus.opE[1] ? '0  : opa)  : '0;

  // One iteration step of each algorithm and the sign-corrected results
  logic [XLEN:0]     mul_hi, r_sh, diff;
  logic [2*XLEN-1:0] prod_next, prod_fin;
  logic [XLEN-1:0]   rem_next, quo_next, mul_res, div_res;
  logic              ge;

  assign mul_hi    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign prod_next = {mul_hi, lo_q[XLEN-1:1]};
  assign prod_fin  = cneg2(neg_q, prod_next);
  assign mul_res   = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

  assign r_sh      = {acc_q, lo_q[XLEN-1]};
  assign diff      = r_sh - {1'b0, opb_q};
  assign ge        = ~diff[XLEN];
  assign rem_next  = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign quo_next  = {lo_q[XLEN-2:0], ge};
  assign div_res   = op_q[1] ? cneg(negr_q, rem_next) : cneg(neg_q, quo_next);

  // Next-state, datapath update and result capture on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_d    = md_q;
    rdo_d   = rdo_q;
    done_d  = 1'b0;
    op_d    = op_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    short_d = short_q;
    case (state_q)
      S_IDLE: begin
        if (bus.startE) begin
          state_d = bus.opE[2] ? S_DIV : S_MUL;
          cnt_d   = CW'(XLEN);
          op_d    = bus.opE;
          rd_d    = bus.rdE;
          acc_d   = '0;
          neg_d   = a_neg ^ b_neg;
          negr_d  = a_neg;
          short_d = special;
          if (bus.opE[2]) begin
            lo_d  = special ? special_res : a_mag;
            opb_d = b_mag;
          end else begin
            lo_d  = special ? special_res : b_mag;
            opb_d = a_mag;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (short_q) begin
          state_d = S_DONE;
          cnt_d   = '0;
          md_d    = lo_q;
          rdo_d   = rd_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (state_q == S_MUL) begin
            acc_d = mul_hi[XLEN:1];
            lo_d  = {mul_hi[0], lo_q[XLEN-1:1]};
          end else begin
            acc_d = rem_next;
            lo_d  = quo_next;
          end
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            md_d    = (state_q == S_MUL) ? mul_res : div_res;
            rdo_d   = rd_q;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flushE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      md_d    = md_q;
      rdo_d   = rdo_q;
      done_d  = 1'b0;
    end
  end

  // Control and architecturally visible outputs, cleared by asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_q    <= '0;
      rdo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_q    <= md_d;
      rdo_q   <= rdo_d;
      done_q  <= done_d;
    end
  end

  // Iteration datapath; contents are only meaningful while an operation runs
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    rd_q    <= rd_d;
    acc_q   <= acc_d;
    lo_q    <= lo_d;
    opb_q   <= opb_d;
    neg_q   <= neg_d;
    negr_q  <= negr_d;
    short_q <= short_d;
  end

  assign bus.busy   = ~rst & (((state_q == S_IDLE) & bus.startE) |
                              (state_q == S_MUL) | (state_q == S_DIV));
  assign bus.done   = done_q;
  assign bus.md_out = md_q;
  assign bus.rd_out = rdo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (XLEN=32): stimulus pushes expected
// results, a monitor pops and compares them on every done pulse.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    logic [31:0] md;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] last_md;

  ex_muldiv_unit_if #(.XLEN(32)) bus();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result and its cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("md_out", {32'd0, bus.md_out}, {32'd0, e.md});
          check("rd_out", {59'd0, bus.rd_out}, {59'd0, e.rd});
          check("done_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        e = q.pop_front();
        check("done_timeout", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] m,
                       input logic [31:0] w, input logic [4:0] rd, input logic [31:0] expv,
                       input int lat, input bit push);
    @(posedge clk); #1;
    bus.startE  = 1'b1;
    bus.opE     = op;
    bus.fwdAE   = fa;
    bus.fwdBE   = fb;
    bus.rs1valE = r1;
    bus.rs2valE = r2;
    bus.resultM = m;
    bus.resultW = w;
    bus.rdE     = rd;
    if (push) q.push_back('{expv, rd, cyc + lat});
    #1;
    check("busy_at_start", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1;
    bus.startE  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 120) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) check("wait_bound", 64'(q.size()), 64'd0);
  endtask

  task automatic op_reg(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input int lat);
    issue(op, 2'b00, 2'b00, a, b, 32'h0, 32'h0, rd, expv, lat, 1'b1);
    wait_done();
    last_md = expv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    cyc = 0; errors = 0; checks = 0; last_md = 32'h0;
    rst = 1'b1;
    bus.startE = 1'b0; bus.opE = 3'd0; bus.fwdAE = 2'd0; bus.fwdBE = 2'd0;
    bus.rs1valE = 32'h0; bus.rs2valE = 32'h0; bus.resultM = 32'h0; bus.resultW = 32'h0;
    bus.rdE = 5'd0; bus.flushE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_md_out", {32'd0, bus.md_out}, 64'd0);
    check("rst_rd_out", {59'd0, bus.rd_out}, 64'd0);
    rst = 1'b0;

    // MUL 7 (via resultM) x -3, busy through T+32 and low in DONE
    issue(3'b000, 2'b01, 2'b00, 32'h55, 32'hFFFFFFFD, 32'd7, 32'h0, 5'd5, 32'hFFFFFFEB, 33, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      check("busy_mul", {63'd0, bus.busy}, 64'd1);
      @(posedge clk); #1;
    end
    check("busy_in_done", {63'd0, bus.busy}, 64'd0);
    wait_done();
    last_md = 32'hFFFFFFEB;

    op_reg(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 33);
    op_reg(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 33);
    op_reg(3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8, 32'hFFFFFFFF, 33);
    op_reg(3'b000, 32'd12345, 32'd1000, 5'd31, 32'd12345000, 33);
    op_reg(3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 33);
    op_reg(3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 33);
    // DIVU 100/7 with divisor forwarded from resultW
    issue(3'b101, 2'b00, 2'b10, 32'd100, 32'd3, 32'h0, 32'd7, 5'd11, 32'd14, 33, 1'b1);
    wait_done();
    // REMU 100/7 with select 11 meaning register file
    issue(3'b111, 2'b11, 2'b11, 32'd100, 32'd7, 32'd1, 32'd1, 5'd12, 32'd2, 33, 1'b1);
    wait_done();
    op_reg(3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 2);
    op_reg(3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 2);
    op_reg(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 2);
    op_reg(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 2);

    // Flush at T+10 with an ignored start at T+5, then a fresh start at T+12
    issue(3'b000, 2'b00, 2'b00, 32'd3, 32'd4, 32'h0, 32'h0, 5'd17, 32'd0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.startE = 1'b1; bus.opE = 3'b100; bus.rdE = 5'd18;
    #1;
    check("busy_ignored_start", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1;
    bus.startE = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flushE = 1'b1;
    @(posedge clk); #1;
    bus.flushE = 1'b0;
    check("busy_after_flush", {63'd0, bus.busy}, 64'd0);
    check("md_hold_after_flush", {32'd0, bus.md_out}, {32'd0, last_md});
    op_reg(3'b000, 32'd6, 32'd7, 5'd19, 32'd42, 33);

    // Reset mid-operation at T+15, then the first start afterwards is accepted
    issue(3'b101, 2'b00, 2'b00, 32'd1000, 32'd10, 32'h0, 32'h0, 5'd20, 32'd0, 0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midop_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("midop_rst_done", {63'd0, bus.done}, 64'd0);
    check("midop_rst_md_out", {32'd0, bus.md_out}, 64'd0);
    check("midop_rst_rd_out", {59'd0, bus.rd_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    op_reg(3'b101, 32'd1000, 32'd10, 5'd21, 32'd100, 33);

    // Multiply by zero: shortcut only when the early-out build is selected
`ifdef MULDIV_EARLY_OUT_EN
    op_reg(3'b000, 32'd0, 32'd9, 5'd22, 32'd0, 2);
`else
    op_reg(3'b000, 32'd0, 32'd9, 5'd22, 32'd0, 33);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
